// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron array.
// The optional shift leak is enabled by defining LIF_SHIFT_LEAK_EN.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } lif_state_e;

    localparam int DEF_NUM_NEURONS       = 16;
    localparam int DEF_CURRENT_WIDTH     = 10;
    localparam int DEF_POTENTIAL_WIDTH   = 16;
    localparam int DEF_REFRACTORY_PERIOD = 8;

    // Unsigned add clamped to 2^width-1; operands are carried in 32 bits,
    // so width must stay below 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

    // Subtractive leak floored at zero, or proportional leak s - (s >> shift).
    function automatic logic [31:0] apply_leak(input logic [31:0] s,
                                               input logic [31:0] leak,
                                               input logic [3:0]  shift,
                                               input logic        mode);
        if (mode) begin
            return s - (s >> shift);
        end
        return (s > leak) ? (s - leak) : 32'd0;
    endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational update of one neuron: integrate, leak, threshold, refractory.
// Defining LIF_SHIFT_LEAK_EN adds the leak_shift / leak_mode inputs.
module lif_update_core
    import lif_pkg::*;
#(
    parameter int POTENTIAL_WIDTH   = DEF_POTENTIAL_WIDTH,
    parameter int REF_WIDTH         = 4,
    parameter int REFRACTORY_PERIOD = DEF_REFRACTORY_PERIOD
) (
    input  logic [POTENTIAL_WIDTH-1:0] v,
    input  logic [POTENTIAL_WIDTH-1:0] acc,
    input  logic [REF_WIDTH-1:0]       ref_cnt,
    input  logic [POTENTIAL_WIDTH-1:0] leak_value,
    input  logic [POTENTIAL_WIDTH-1:0] threshold,
`ifdef LIF_SHIFT_LEAK_EN
    input  logic [3:0]                 leak_shift,
    input  logic                       leak_mode,
`endif
    output logic [POTENTIAL_WIDTH-1:0] v_next,
    output logic [REF_WIDTH-1:0]       ref_next,
    output logic                       fire
);

    logic [31:0] sum;
    logic [31:0] leaked;
    logic [3:0]  shift_amt;
    logic        shift_mode;

`ifdef LIF_SHIFT_LEAK_EN
    assign shift_amt  = leak_shift;
    assign shift_mode = leak_mode;
`else
    assign shift_amt  = 4'd0;
    assign shift_mode = 1'b0;
`endif

    // Refractory neurons only count down; active ones integrate, leak and test.
    always_comb begin
        sum      = sat_add(32'(v), 32'(acc), POTENTIAL_WIDTH);
        leaked   = apply_leak(sum, 32'(leak_value), shift_amt, shift_mode);
        v_next   = v;
        ref_next = ref_cnt;
        fire     = 1'b0;
        if (ref_cnt != '0) begin
            ref_next = ref_cnt - REF_WIDTH'(1);
        end else if (leaked >= 32'(threshold)) begin
            fire     = 1'b1;
            v_next   = '0;
            ref_next = REF_WIDTH'(REFRACTORY_PERIOD);
        end else begin
            v_next   = leaked[POTENTIAL_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array: currents accumulate while idle, a step
// pulse sweeps every neuron through one shared update core, spikes leave as
// an indexed valid/ready stream. Defining LIF_SHIFT_LEAK_EN adds the shift leak.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS       = DEF_NUM_NEURONS,
    parameter int CURRENT_WIDTH     = DEF_CURRENT_WIDTH,
    parameter int POTENTIAL_WIDTH   = DEF_POTENTIAL_WIDTH,
    parameter int REFRACTORY_PERIOD = DEF_REFRACTORY_PERIOD
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cur_valid,
    output logic                           cur_ready,
    input  logic [$clog2(NUM_NEURONS)-1:0] cur_idx,
    input  logic [CURRENT_WIDTH-1:0]       cur_data,
    input  logic                           step,
    input  logic [POTENTIAL_WIDTH-1:0]     leak_value,
    input  logic [POTENTIAL_WIDTH-1:0]     threshold,
`ifdef LIF_SHIFT_LEAK_EN
    input  logic [3:0]                     leak_shift,
    input  logic                           leak_mode,
`endif
    output logic                           spk_valid,
    input  logic                           spk_ready,
    output logic [$clog2(NUM_NEURONS)-1:0] spk_idx,
    output logic                           busy,
    output logic                           step_done,
    output logic                           step_miss
);

    localparam int IDX_WIDTH = $clog2(NUM_NEURONS);
    localparam int REF_WIDTH = (REFRACTORY_PERIOD < 1) ? 1 : $clog2(REFRACTORY_PERIOD + 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    lif_state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]       idx_q, idx_d;
    logic                       spk_valid_q, spk_valid_d;
    logic [IDX_WIDTH-1:0]       spk_idx_q, spk_idx_d;
    logic [POTENTIAL_WIDTH-1:0] v_q   [NUM_NEURONS];
    logic [POTENTIAL_WIDTH-1:0] v_d   [NUM_NEURONS];
    logic [POTENTIAL_WIDTH-1:0] acc_q [NUM_NEURONS];
    logic [POTENTIAL_WIDTH-1:0] acc_d [NUM_NEURONS];
    logic [REF_WIDTH-1:0]       ref_q [NUM_NEURONS];
    logic [REF_WIDTH-1:0]       ref_d [NUM_NEURONS];

    logic                       proc_en;
    logic                       acc_we;
    logic [31:0]                acc_sum;
    logic [POTENTIAL_WIDTH-1:0] core_v;
    logic [REF_WIDTH-1:0]       core_ref;
    logic                       core_fire;

    // A pending spike that is not being taken freezes the sweep, so the
    // single-entry spike slot can never be overwritten.
    assign proc_en   = (state_q == SWEEP) && !(spk_valid_q && !spk_ready);
    assign cur_ready = (state_q == IDLE);
    assign acc_we    = cur_valid && cur_ready;
    assign busy      = (state_q != IDLE);
    assign step_done = (state_q == DONE);
    assign step_miss = step && (state_q != IDLE);
    assign spk_valid = spk_valid_q;
    assign spk_idx   = spk_idx_q;

    lif_update_core #(
        .POTENTIAL_WIDTH  (POTENTIAL_WIDTH),
        .REF_WIDTH        (REF_WIDTH),
        .REFRACTORY_PERIOD(REFRACTORY_PERIOD)
    ) u_core (
        .v         (v_q[idx_q]),
        .acc       (acc_q[idx_q]),
        .ref_cnt   (ref_q[idx_q]),
        .leak_value(leak_value),
        .threshold (threshold),
`ifdef LIF_SHIFT_LEAK_EN
        .leak_shift(leak_shift),
        .leak_mode (leak_mode),
`endif
        .v_next    (core_v),
        .ref_next  (core_ref),
        .fire      (core_fire)
    );

    // Per-neuron next state: the swept neuron takes the core result, otherwise
    // an accepted current beat saturating-adds into its accumulator.
    always_comb begin
        acc_sum = sat_add(32'(acc_q[cur_idx]), 32'(cur_data), POTENTIAL_WIDTH);
        for (int i = 0; i < NUM_NEURONS; i++) begin
            v_d[i]   = v_q[i];
            acc_d[i] = acc_q[i];
            ref_d[i] = ref_q[i];
            if (proc_en && (idx_q == IDX_WIDTH'(i))) begin
                v_d[i]   = core_v;
                acc_d[i] = '0;
                ref_d[i] = core_ref;
            end else if (acc_we && (cur_idx == IDX_WIDTH'(i))) begin
                acc_d[i] = acc_sum[POTENTIAL_WIDTH-1:0];
            end
        end
    end

    // Sweep FSM and spike slot; a new spike load takes priority over a drain.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        spk_valid_d = spk_valid_q;
        spk_idx_d   = spk_idx_q;
        if (spk_valid_q && spk_ready) begin
            spk_valid_d = 1'b0;
        end
        if (proc_en && core_fire) begin
            spk_valid_d = 1'b1;
            spk_idx_d   = idx_q;
        end
        unique case (state_q)
            IDLE: begin
                if (step) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (proc_en) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (!spk_valid_q || spk_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any sweep and clears every neuron.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]   <= '0;
                acc_q[i] <= '0;
                ref_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            spk_valid_q <= spk_valid_d;
            spk_idx_q   <= spk_idx_d;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]   <= v_d[i];
                acc_q[i] <= acc_d[i];
                ref_q[i] <= ref_d[i];
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array against a behavioural neuron model.
module tb_lif_neuron_array;

    localparam int N    = 12;
    localparam int CW   = 10;
    localparam int PW   = 16;
    localparam int RP   = 8;
    localparam int IW   = 4;
    localparam int PMAX = 65535;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cur_valid = 1'b0;
    logic          step      = 1'b0;
    logic          spk_ready = 1'b1;
    logic [IW-1:0] cur_idx   = '0;
    logic [CW-1:0] cur_data  = '0;
    logic [PW-1:0] leak_value = '0;
    logic [PW-1:0] threshold  = '0;
    logic          cur_ready, spk_valid, busy, step_done, step_miss;
    logic [IW-1:0] spk_idx;

    int errors = 0;
    int checks = 0;
    int m_v   [N];
    int m_acc [N];
    int m_ref [N];

    always #5 clk = ~clk;

    lif_neuron_array #(
        .NUM_NEURONS      (N),
        .CURRENT_WIDTH    (CW),
        .POTENTIAL_WIDTH  (PW),
        .REFRACTORY_PERIOD(RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cur_valid (cur_valid),
        .cur_ready (cur_ready),
        .cur_idx   (cur_idx),
        .cur_data  (cur_data),
        .step      (step),
        .leak_value(leak_value),
        .threshold (threshold),
`ifdef LIF_SHIFT_LEAK_EN
        .leak_shift(4'd0),
        .leak_mode (1'b0),
`endif
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .spk_idx   (spk_idx),
        .busy      (busy),
        .step_done (step_done),
        .step_miss (step_miss)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_acc[i] = 0; m_ref[i] = 0;
        end
    endtask

    task automatic model_beat(input int idx, input int data);
        if (idx < N) begin
            m_acc[idx] = (m_acc[idx] + data > PMAX) ? PMAX : m_acc[idx] + data;
        end
    endtask

    // One timestep of every neuron, straight from the neuron rules.
    task automatic model_step(input int leak, input int thr, output int fired[$]);
        int s;
        fired = {};
        for (int i = 0; i < N; i++) begin
            if (m_ref[i] > 0) begin
                m_ref[i]--;
            end else begin
                s = m_v[i] + m_acc[i];
                if (s > PMAX) s = PMAX;
                s = (s > leak) ? s - leak : 0;
                if (s >= thr) begin
                    fired.push_back(i);
                    m_v[i]   = 0;
                    m_ref[i] = RP;
                end else begin
                    m_v[i] = s;
                end
            end
            m_acc[i] = 0;
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic inject(input int idx, input int data);
        cur_valid = 1'b1;
        cur_idx   = IW'(idx);
        cur_data  = CW'(data);
        @(negedge clk);
        check("inject_cur_ready", int'(cur_ready), 1);
        @(posedge clk); #1;
        cur_valid = 1'b0;
        model_beat(idx, data);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_spk_valid", int'(spk_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cur_ready", int'(cur_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic sweep(input int leak, input int thr, input int k, input int miss_off,
                         input bit beat_en, input int bidx, input int bdata);
        int exp_q[$];
        int got_idx[$];
        int got_off[$];
        int done_off;
        int lowcnt;
        int misses;
        leak_value = PW'(leak);
        threshold  = PW'(thr);
        step = 1'b1;
        if (beat_en) begin
            cur_valid = 1'b1;
            cur_idx   = IW'(bidx);
            cur_data  = CW'(bdata);
            model_beat(bidx, bdata);
        end
        model_step(leak, thr, exp_q);
        @(negedge clk);
        check("step_cycle_busy", int'(busy), 0);
        @(posedge clk); #1;
        step = 1'b0;
        cur_valid = 1'b0;
        done_off = -1;
        lowcnt = 0;
        misses = 0;
        for (int off = 1; off <= 4 * N + 40; off++) begin
            step      = (off == miss_off);
            spk_ready = (lowcnt < k) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (off == 1) check("busy_after_step", int'(busy), 1);
            if (step_miss) misses++;
            if (spk_valid && !spk_ready) lowcnt++;
            if (spk_valid && spk_ready) begin
                got_idx.push_back(int'(spk_idx));
                got_off.push_back(off);
            end
            if (step_done) done_off = off;
            @(posedge clk); #1;
            if (done_off >= 0) break;
        end
        step = 1'b0;
        spk_ready = 1'b1;
        check("step_done_offset", done_off, N + 2 + ((exp_q.size() > 0) ? k : 0));
        check("step_miss_pulses", misses, (miss_off > 0) ? 1 : 0);
        check("spike_count", got_idx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_idx.size(); i++) begin
            check("spike_idx", got_idx[i], exp_q[i]);
            if (k == 0) check("spike_time", got_off[i], 2 + exp_q[i]);
        end
        @(negedge clk);
        check("cur_ready_after", int'(cur_ready), 1);
        check("busy_after", int'(busy), 0);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("v_%0d", i), int'(dut.v_q[i]), m_v[i]);
        end
        $display("sweep leak=%0d thr=%0d stall=%0d spikes=%0d done_off=%0d",
                 leak, thr, k, got_idx.size(), done_off);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        // Reset defaults while rst_n is held low from time zero.
        @(negedge clk);
        check("rst0_spk_valid", int'(spk_valid), 0);
        check("rst0_spk_idx", int'(spk_idx), 0);
        check("rst0_step_done", int'(step_done), 0);
        check("rst0_step_miss", int'(step_miss), 0);
        check("rst0_busy", int'(busy), 0);
        check("rst0_cur_ready", int'(cur_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset in the middle of a sweep with spikes pending.
        inject(0, 500);
        inject(1, 500);
        threshold = PW'(1);
        leak_value = '0;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        do_reset();
        check("midrst_spk_idx", int'(spk_idx), 0);
        check("midrst_step_done", int'(step_done), 0);
        sweep(5, 100, 0, 0, 1'b0, 0, 0);

        // Single fire, then refractory blocking despite large input.
        inject(3, 105);
        sweep(5, 100, 0, 0, 1'b0, 0, 0);
        repeat (8) begin
            inject(3, 200);
            sweep(5, 100, 0, 0, 1'b0, 0, 0);
        end

        // Sub-threshold leak.
        inject(0, 50);
        sweep(20, 100, 0, 0, 1'b0, 0, 0);
        sweep(20, 100, 0, 0, 1'b0, 0, 0);

        // Accumulator saturation and an out-of-range beat.
        repeat (100) inject(1, 1023);
        inject(13, 777);
        for (int i = 0; i < N; i++) begin
            check($sformatf("acc_%0d", i), int'(dut.acc_q[i]), m_acc[i]);
        end
        sweep(5, 60000, 0, 0, 1'b0, 0, 0);

        // All neurons fire with backpressure on the first spike.
        do_reset();
        sweep(0, 0, 3, 0, 1'b0, 0, 0);

        // step while busy is ignored.
        sweep(5, 100, 0, 3, 1'b0, 0, 0);

        // Randomized traffic, including a beat in the step cycle.
        for (int r = 0; r < 8; r++) begin
            int nbeats;
            nbeats = $urandom_range(0, 10);
            for (int b = 0; b < nbeats; b++) begin
                inject($urandom_range(0, 15), $urandom_range(0, 1023));
            end
            sweep($urandom_range(0, 40), $urandom_range(30, 900), $urandom_range(0, 3),
                  ($urandom_range(0, 1) == 1) ? $urandom_range(1, N) : 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, N - 1), $urandom_range(0, 1023));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Time-multiplexed array of NUM_NEURONS leaky integrate-and-fire neurons sharing one update datapath, with per-neuron potential, input accumulator and refractory state held in registers. Weighted currents stream in between timesteps. A `step` pulse sweeps every neuron once, and spike events leave as an indexed valid/ready stream. It is the parametrised successor to the single-neuron LIF cell and sits between the synapse/crossbar stage and the spike router.

## Interface
- NUM_NEURONS, 16: neurons in the array (≥2).
- CURRENT_WIDTH, 10: unsigned input current width.
- POTENTIAL_WIDTH, 16: unsigned membrane potential and accumulator width (> CURRENT_WIDTH).
- REFRACTORY_PERIOD, 8: number of timesteps a neuron is skipped after firing (≥0).
- IDX_WIDTH, $clog2(NUM_NEURONS): neuron index width (derived, not overridden).

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- cur_valid, in, 1: current beat valid.
- cur_ready, out, 1: current beat accepted; equals (state==IDLE).
- cur_idx, in, IDX_WIDTH: target neuron.
- cur_data, in, CURRENT_WIDTH: current magnitude.
- step, in, 1: single-cycle timestep trigger.
- leak_value, in, POTENTIAL_WIDTH: subtractive leak per step.
- threshold, in, POTENTIAL_WIDTH: fire threshold.
- spk_valid, out, 1: spike event valid.
- spk_ready, in, 1: downstream accepts event.
- spk_idx, out, IDX_WIDTH: index of the firing neuron.
- busy, out, 1: sweep in progress (state≠IDLE).
- step_done, out, 1: one-cycle pulse at the end of a sweep.
- step_miss, out, 1: one-cycle pulse when `step` arrives while busy.

## Operation
- Reset: all potentials, accumulators and refractory counters are cleared to 0. State=IDLE. Outputs during and after reset: spk_valid=0, spk_idx=0, step_done=0, step_miss=0, busy=0, cur_ready=1.
- Reset mid-sweep: the sweep is abandoned and all state is cleared. No step_done is produced.
- FSM states: IDLE→SWEEP on `step`. SWEEP→DRAIN after neuron NUM_NEURONS-1 is processed. DRAIN→DONE when the spike slot is empty or being accepted. DONE→IDLE unconditionally. DONE lasts one cycle with step_done=1.
- IDLE accumulation: on cur_valid&&cur_ready, acc[cur_idx] ← min(acc + cur_data, 2^POTENTIAL_WIDTH−1). Beats with cur_idx ≥ NUM_NEURONS are accepted and dropped.
- A current beat accepted in the same cycle as `step` counts toward that step.
- SWEEP processes one neuron per cycle, indices 0..N−1 in order. The sweep stalls (index and state held) in any cycle where spk_valid && !spk_ready.
- Refractory neuron (ref>0): ref ← ref−1, acc ← 0, V unchanged, no spike.
- Active neuron:
  - s = sat(V + acc).
  - s = (s > leak_value) ? s − leak_value : 0.
  - If s ≥ threshold: spike, V ← 0, ref ← REFRACTORY_PERIOD.
  - Else: V ← s.
  - In both cases acc ← 0.
- Spike slot: a registered single entry loaded with the neuron index. It clears on spk_valid && spk_ready. It cannot overflow because of the stall rule.
- threshold=0: every non-refractory neuron fires every step.
- `step` received while busy: the step is ignored and step_miss pulses.

## Timing
- `step` at cycle t, spk_ready held 1: neuron i is processed in cycle t+1+i.
- The spike for neuron i is visible (spk_valid) at t+2+i.
- DRAIN occurs at t+N+1. DONE/step_done occurs at t+N+2. cur_ready=1 again at t+N+3.
- busy is high from t+1 through t+N+2.
- Each cycle spk_ready is low while a spike is pending adds exactly one cycle to the sweep.

## Configuration
- `LIF_SHIFT_LEAK_EN` defined: adds input `leak_shift` [3:0] and input `leak_mode` (1 bit). When leak_mode=1, the leak is s − (s >> leak_shift) instead of the subtractive leak. leak_shift=0 yields 0.
- `LIF_SHIFT_LEAK_EN` undefined: these ports are absent and only the subtractive leak exists.

## Structure
- Package `lif_pkg`:
  - FSM state enum (IDLE, SWEEP, DRAIN, DONE).
  - Saturating-add function.
  - Leak function.
  - Default width constants.
- Sub-module `lif_update_core`: combinational per-neuron update (V, acc, ref, params in; V', ref', fire out). The array instantiates it once.

## Test plan
- Reset defaults:
  - Stimulus: pulse rst_n low mid-sweep.
  - Response: all outputs at reset values next cycle. A following step with no currents produces no spikes, and step_done arrives at t+N+2.
- Single fire:
  - Stimulus: threshold=100, leak=5, 105 into neuron 3, then step.
  - Response: spk_idx=3 at t+5, V[3]=0. The next 8 steps produce no spike from neuron 3, even with 200 injected each step.
- Sub-threshold leak:
  - Stimulus: 50 into neuron 0, leak=20, threshold=100, two steps with no further input.
  - Response: V=30, then 10. No spike.
- Saturation and invalid index:
  - Stimulus: 100×1023 into neuron 1 (P=16), plus a beat to idx ≥ N.
  - Response: acc saturates at 65535, the neuron fires, and the stray beat is dropped with no effect.
- Backpressure:
  - Stimulus: all neurons fire with spk_ready low for 3 cycles after the first spike.
  - Response: spikes arrive in order 0..N−1, none lost, step_done delayed by 3 cycles.
- step_miss:
  - Stimulus: `step` while busy.
  - Response: step_miss pulses once. No extra sweep occurs.
